// File: rtl/ddr3_rx_iod_train_ctrl.sv
// ---------------------------------------------------------------------------
// ddr3_rx_iod_train_ctrl
//
// Trains one DDR3 receive IOD lane (1:4 deserialised data) against a known,
// repeating training word. The controller first sweeps the IOD dynamic delay
// line from tap 0 upward, looking for the first contiguous run of taps where
// the captured word is stable and is some rotation of PATTERN. It then reloads
// the delay line, steps it to the centre of that window, and issues bit slips
// until the captured word equals PATTERN exactly.
//
// Ports
//   FAB_CLK                  fabric clock, all logic on the rising edge
//   RX_SYNC_RST              synchronous active-high reset
//   START                    one-cycle pulse to begin training (ignored when BUSY)
//   RX_DATA[3:0]             deserialised word from the input IOD
//   DELAY_LINE_OUT_OF_RANGE  IOD delay line has reached its limit
//   DELAY_LINE_MOVE          one-cycle tap step pulse
//   DELAY_LINE_DIRECTION     step direction, 1 = increment (high with MOVE)
//   DELAY_LINE_LOAD          one-cycle pulse returning the delay line to tap 0
//   RX_BIT_SLIP              one-cycle bit-slip pulse
//   BUSY                     training in progress
//   TRAIN_DONE               training succeeded (held until START/reset)
//   TRAIN_FAIL               training failed (held until START/reset)
//   TAP_VALUE[7:0]           current tap index
//   WIN_START[7:0]           first passing tap of the window
//   WIN_END[7:0]             last passing tap of the window
//   SLIP_COUNT[1:0]          bit slips issued
//
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module ddr3_rx_iod_train_ctrl #(
    parameter logic [3:0] PATTERN    = 4'b0011,
    parameter int         MAX_TAPS   = 128,
    parameter int         SETTLE_CYC = 8,
    parameter int         SAMPLE_CNT = 16
) (
    input  logic       FAB_CLK,
    input  logic       RX_SYNC_RST,
    input  logic       START,
    input  logic [3:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_LOAD,
    output logic       RX_BIT_SLIP,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_FAIL,
    output logic [7:0] TAP_VALUE,
    output logic [7:0] WIN_START,
    output logic [7:0] WIN_END,
    output logic [1:0] SLIP_COUNT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_SCAN   = 3'd4,
        ST_MOVE   = 3'd5,
        ST_CENTER = 3'd6,
        ST_ALIGN  = 3'd7
    } state_t;

    // True when word equals one of the four rotations of PATTERN.
    function automatic logic is_rotation(input logic [3:0] word);
        logic [3:0] rot;
        logic       hit;
        rot = PATTERN;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = hit | (word == rot);
            rot = {rot[2:0], rot[3]};
        end
        return hit;
    endfunction

    // Registered state.
    state_t     state_r, ret_r;
    logic [7:0] settle_cnt_r;
    logic [4:0] sample_cnt_r;
    logic [3:0] ref_r;
    logic       mismatch_r;
    logic       have_win_r;
    logic [7:0] target_r;
    logic [7:0] tap_r, win_start_r, win_end_r;
    logic [1:0] slip_cnt_r;
    logic       busy_r, done_r, fail_r;
    logic       load_r, move_r, dir_r, slip_r;

    // Next-state values.
    state_t     state_s, ret_s;
    logic [7:0] settle_cnt_s;
    logic [4:0] sample_cnt_s;
    logic [3:0] ref_s;
    logic       mismatch_s;
    logic       have_win_s;
    logic [7:0] target_s;
    logic [7:0] tap_s, win_start_s, win_end_s;
    logic [1:0] slip_cnt_s;
    logic       busy_s, done_s, fail_s;
    logic       load_s, move_s, dir_s, slip_s;

    // Scan evaluation helpers.
    logic       pass_s;
    logic       at_limit_s;
    logic       end_scan_s;
    logic [8:0] win_sum_s;

    // Next-state and next-output logic for the training sequence.
    always_comb begin
        state_s      = state_r;
        ret_s        = ret_r;
        settle_cnt_s = settle_cnt_r;
        sample_cnt_s = sample_cnt_r;
        ref_s        = ref_r;
        mismatch_s   = mismatch_r;
        have_win_s   = have_win_r;
        target_s     = target_r;
        tap_s        = tap_r;
        win_start_s  = win_start_r;
        win_end_s    = win_end_r;
        slip_cnt_s   = slip_cnt_r;
        busy_s       = busy_r;
        done_s       = done_r;
        fail_s       = fail_r;
        // Strobes are single-cycle: low unless a state below raises them.
        load_s       = 1'b0;
        move_s       = 1'b0;
        dir_s        = 1'b0;
        slip_s       = 1'b0;
        pass_s       = 1'b0;
        at_limit_s   = 1'b0;
        end_scan_s   = 1'b0;
        win_sum_s    = 9'd0;

        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    fail_s       = 1'b0;
                    tap_s        = 8'd0;
                    win_start_s  = 8'd0;
                    win_end_s    = 8'd0;
                    slip_cnt_s   = 2'd0;
                    have_win_s   = 1'b0;
                    target_s     = 8'd0;
                    sample_cnt_s = 5'd0;
                    ret_s        = ST_SAMPLE;
                    state_s      = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                load_s       = 1'b1;
                tap_s        = 8'd0;
                settle_cnt_s = 8'd0;
                state_s      = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (settle_cnt_r == 8'(SETTLE_CYC - 1)) begin
                    settle_cnt_s = 8'd0;
                    state_s      = ret_r;
                end else begin
                    settle_cnt_s = settle_cnt_r + 8'd1;
                end
            end

            ST_SAMPLE: begin
                // First word becomes the reference; later words must match it.
                if (sample_cnt_r == 5'd0) begin
                    ref_s      = RX_DATA;
                    mismatch_s = 1'b0;
                end else if (RX_DATA != ref_r) begin
                    mismatch_s = 1'b1;
                end else begin
                    mismatch_s = mismatch_r;
                end
                if (sample_cnt_r < 5'(SAMPLE_CNT)) begin
                    sample_cnt_s = sample_cnt_r + 5'd1;
                end else begin
                    sample_cnt_s = sample_cnt_r;
                end
                if (sample_cnt_r == 5'(SAMPLE_CNT - 1)) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end

            ST_SCAN: begin
                sample_cnt_s = 5'd0;
                pass_s       = !mismatch_r && is_rotation(ref_r);
                at_limit_s   = (tap_r == 8'(MAX_TAPS - 1)) || DELAY_LINE_OUT_OF_RANGE;
                if (pass_s) begin
                    if (!have_win_r) begin
                        win_start_s = tap_r;
                    end else begin
                        win_start_s = win_start_r;
                    end
                    win_end_s  = tap_r;
                    have_win_s = 1'b1;
                    end_scan_s = at_limit_s;
                end else begin
                    // A fail after a window closes it: only the first window counts.
                    end_scan_s = have_win_r || at_limit_s;
                end
                if (end_scan_s) begin
                    if (have_win_s) begin
                        win_sum_s = {1'b0, win_start_s} + {1'b0, win_end_s};
                        target_s  = win_sum_s[8:1];
                        ret_s     = ST_CENTER;
                        state_s   = ST_LOAD;
                    end else begin
                        fail_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_MOVE;
                end
            end

            ST_MOVE: begin
                move_s       = 1'b1;
                dir_s        = 1'b1;
                tap_s        = tap_r + 8'd1;
                settle_cnt_s = 8'd0;
                state_s      = ST_SETTLE;
            end

            ST_CENTER: begin
                // ret_r stays ST_CENTER so each MOVE settles and returns here.
                if (tap_r == target_r) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_MOVE;
                end
            end

            ST_ALIGN: begin
                if (RX_DATA == PATTERN) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else if (slip_cnt_r == 2'd3) begin
                    fail_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    slip_s       = 1'b1;
                    slip_cnt_s   = slip_cnt_r + 2'd1;
                    settle_cnt_s = 8'd0;
                    ret_s        = ST_ALIGN;
                    state_s      = ST_SETTLE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_r      <= ST_IDLE;
            ret_r        <= ST_IDLE;
            settle_cnt_r <= 8'd0;
            sample_cnt_r <= 5'd0;
            ref_r        <= 4'd0;
            mismatch_r   <= 1'b0;
            have_win_r   <= 1'b0;
            target_r     <= 8'd0;
            tap_r        <= 8'd0;
            win_start_r  <= 8'd0;
            win_end_r    <= 8'd0;
            slip_cnt_r   <= 2'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            load_r       <= 1'b0;
            move_r       <= 1'b0;
            dir_r        <= 1'b0;
            slip_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            ret_r        <= ret_s;
            settle_cnt_r <= settle_cnt_s;
            sample_cnt_r <= sample_cnt_s;
            ref_r        <= ref_s;
            mismatch_r   <= mismatch_s;
            have_win_r   <= have_win_s;
            target_r     <= target_s;
            tap_r        <= tap_s;
            win_start_r  <= win_start_s;
            win_end_r    <= win_end_s;
            slip_cnt_r   <= slip_cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            fail_r       <= fail_s;
            load_r       <= load_s;
            move_r       <= move_s;
            dir_r        <= dir_s;
            slip_r       <= slip_s;
        end
    end

    assign DELAY_LINE_MOVE      = move_r;
    assign DELAY_LINE_DIRECTION = dir_r;
    assign DELAY_LINE_LOAD      = load_r;
    assign RX_BIT_SLIP          = slip_r;
    assign BUSY                 = busy_r;
    assign TRAIN_DONE           = done_r;
    assign TRAIN_FAIL           = fail_r;
    assign TAP_VALUE            = tap_r;
    assign WIN_START            = win_start_r;
    assign WIN_END              = win_end_r;
    assign SLIP_COUNT           = slip_cnt_r;

endmodule
